// File: rtl/quad_pkg.sv
// quad_pkg: quadrature state type, forward Gray sequence and transition decode
package quad_pkg;
    typedef enum logic [1:0] {Q00 = 2'b00, Q01 = 2'b01, Q10 = 2'b10, Q11 = 2'b11} quad_t;
    typedef struct packed {
        logic inc;
        logic dec;
        logic illegal;
    } quad_dec_t;
    localparam logic [7:0] FWD_SEQ = 8'b00_01_11_10;
    function automatic quad_t fwd_next(input quad_t q);
        quad_t n;
        n = Q00;
        for (int i = 0; i < 4; i++)
            if (FWD_SEQ[7-2*i -: 2] == q) n = quad_t'(FWD_SEQ[7-2*((i+1)%4) -: 2]);
        return n;
    endfunction
    function automatic quad_dec_t quad_decode(input quad_t prev, input quad_t cur);
        quad_dec_t d;
        d.inc = cur == fwd_next(prev);
        d.dec = prev == fwd_next(cur);
        d.illegal = (prev ^ cur) == 2'b11;
        return d;
    endfunction
endpackage

// File: rtl/quad_filter.sv
// quad_filter: two-flop synchronizer plus tick-sampled majority-free glitch filter for one channel
module quad_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic tick,
    input  logic din,
    output logic filt,
    output logic valid
);
    logic [1:0] sync;
    logic [FILT_LEN-1:0] hist, nh;
    always_comb nh = {hist[FILT_LEN-2:0], sync[1]};
    // valid marks the first time the history agreed, so priming never sees an unsettled level
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync  <= '0;
            hist  <= '0;
            filt  <= 1'b0;
            valid <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            if (tick) begin
                hist <= nh;
                if (&nh) begin
                    filt  <= 1'b1;
                    valid <= 1'b1;
                end else if (~|nh) begin
                    filt  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/quad2steer.sv
// quad2steer: quadrature decoder with position count and held left/right steering levels.
// Define QUAD2STEER_SAT_EN to saturate count at 8'h00/8'hFF instead of wrapping.
module quad2steer
    import quad_pkg::*;
#(
    parameter int         CLKDIV   = 5500,
    parameter int         FILT_LEN = 3,
    parameter logic [7:0] CNT_INIT = 8'h80,
    parameter int         HOLD     = 16
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       clr,
    output logic [7:0] count,
    output logic       step,
    output logic       dir,
    output logic       err,
    output logic       left,
    output logic       right
);
    localparam int DW = $clog2(CLKDIV);
    logic [DW-1:0] div;
    logic [7:0] hold, cnt_up, cnt_dn;
    logic tick, fa, fb, va, vb, primed, chg, inc, dec, ill;
    quad_t prev, cur;
    quad_dec_t d;

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk_sys(CLK), .reset_n(Reset_n), .tick(tick), .din(enc_a), .filt(fa), .valid(va)
    );
    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk_sys(CLK), .reset_n(Reset_n), .tick(tick), .din(enc_b), .filt(fb), .valid(vb)
    );

    always_comb begin
        tick = div == DW'(CLKDIV - 1);
        cur  = quad_t'({fa, fb});
        d    = quad_decode(prev, cur);
        chg  = primed && cur != prev;
        inc  = chg && d.inc;
        dec  = chg && d.dec;
        ill  = chg && d.illegal;
`ifdef QUAD2STEER_SAT_EN
        cnt_up = (count == 8'hFF) ? count : count + 8'd1;
        cnt_dn = (count == 8'h00) ? count : count - 8'd1;
`else
        cnt_up = count + 8'd1;
        cnt_dn = count - 8'd1;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            div    <= '0;
            prev   <= Q00;
            primed <= 1'b0;
            count  <= CNT_INIT;
            step   <= 1'b0;
            err    <= 1'b0;
            dir    <= 1'b0;
            left   <= 1'b0;
            right  <= 1'b0;
            hold   <= '0;
        end else begin
            div  <= tick ? '0 : div + 1'b1;
            step <= inc | dec;
            err  <= ill;
            // an illegal pair still becomes the new reference
            if (!primed && va && vb) begin
                prev   <= cur;
                primed <= 1'b1;
            end else if (chg) begin
                prev <= cur;
            end
            if (inc | dec) dir <= inc;
            count <= clr ? CNT_INIT : inc ? cnt_up : dec ? cnt_dn : count;
            if (inc) begin
                hold  <= 8'(HOLD);
                right <= 1'b1;
                left  <= 1'b0;
            end else if (dec) begin
                hold  <= 8'(HOLD);
                left  <= 1'b1;
                right <= 1'b0;
            end else if (tick && hold != 8'd0) begin
                hold <= hold - 8'd1;
                if (hold == 8'd1) begin
                    left  <= 1'b0;
                    right <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_quad2steer.sv
// tb_quad2steer: scoreboard bench for quad2steer with directed quadrature vectors
module tb_quad2steer;
    typedef struct packed {
        logic       is_err;
        logic       dir;
        logic [7:0] count;
        logic       left;
        logic       right;
    } ev_t;

    logic clk = 1'b0, reset_n = 1'b0, enc_a = 1'b0, enc_b = 1'b0, clr = 1'b0;
    logic [7:0] count, w_count;
    logic step, dir, err, left, right, w_step, w_dir, w_err, w_left, w_right;
    ev_t exp_q[$];
    ev_t act_ev, exp_ev;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    quad2steer #(.CLKDIV(4), .FILT_LEN(3), .CNT_INIT(8'h80), .HOLD(2)) u_dut (
        .CLK(clk), .Reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
        .count(count), .step(step), .dir(dir), .err(err), .left(left), .right(right)
    );
    quad2steer #(.CLKDIV(4), .FILT_LEN(3), .CNT_INIT(8'hFE), .HOLD(2)) u_wrap (
        .CLK(clk), .Reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
        .count(w_count), .step(w_step), .dir(w_dir), .err(w_err), .left(w_left), .right(w_right)
    );

    // monitor: every step/err pulse must match the oldest expected event
    always @(negedge clk) begin
        if (step || err) begin
            act_ev = {err, dir, count, left, right};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got err=%0b dir=%0b count=%02h l=%0b r=%0b, none expected",
                         err, dir, count, left, right);
            end else begin
                exp_ev = exp_q.pop_front();
                if (act_ev !== exp_ev) begin
                    fails++;
                    $display("FAIL event: got err=%0b dir=%0b count=%02h l=%0b r=%0b, want err=%0b dir=%0b count=%02h l=%0b r=%0b",
                             act_ev.is_err, act_ev.dir, act_ev.count, act_ev.left, act_ev.right,
                             exp_ev.is_err, exp_ev.dir, exp_ev.count, exp_ev.left, exp_ev.right);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input logic a, input logic b);
        @(negedge clk);
        enc_a = a;
        enc_b = b;
    endtask

    task automatic push(input logic e, input logic dr, input logic [7:0] c, input logic l, input logic r);
        exp_q.push_back({e, dr, c, l, r});
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_step(input int lim);
        int n = 0;
        while (!step && n < lim) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!step) begin
            fails++;
            $display("FAIL step_timeout: got no step within %0d cycles, want a step", lim);
        end
    endtask

    task automatic fwd(input logic a, input logic b, input logic [7:0] c);
        push(1'b0, 1'b1, c, 1'b0, 1'b1);
        set_ab(a, b);
        wait_cyc(16);
    endtask

    initial begin
        do_reset(3);
        check("rst_count", count, 8'h80);
        check("rst_step", step, 0);
        check("rst_err", err, 0);
        check("rst_dir", dir, 0);
        check("rst_left", left, 0);
        check("rst_right", right, 0);
        check("rst_wrap_count", w_count, 8'hFE);
        wait_cyc(16);
        // forward cycle
        fwd(1'b0, 1'b1, 8'h81);
        fwd(1'b1, 1'b1, 8'h82);
        fwd(1'b1, 1'b0, 8'h83);
        push(1'b0, 1'b1, 8'h84, 1'b0, 1'b1);
        set_ab(1'b0, 1'b0);
        wait_step(30);
        wait_cyc(3);
        check("right_held", right, 1);
        wait_cyc(7);
        check("right_dropped", right, 0);
        check("fwd_count", count, 8'h84);
        check("fwd_dir", dir, 1);
        // glitch rejection
        do_reset(3);
        wait_cyc(20);
        set_ab(1'b1, 1'b0);
        wait_cyc(5);
        set_ab(1'b0, 1'b0);
        wait_cyc(30);
        check("glitch_count", count, 8'h80);
        // illegal transition then a legal one
        push(1'b1, 1'b0, 8'h80, 1'b0, 1'b0);
        set_ab(1'b1, 1'b1);
        wait_cyc(16);
        check("ill_count", count, 8'h80);
        check("ill_dir", dir, 0);
        fwd(1'b1, 1'b0, 8'h81);
        check("after_ill_count", count, 8'h81);
        // clear beats a reverse step
        push(1'b0, 1'b0, 8'h80, 1'b1, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        wait_cyc(16);
        clr = 1'b0;
        check("clr_count", count, 8'h80);
        check("clr_left", left, 1);
        check("clr_wrap_count", w_count, 8'hFE);
        // wrap or saturate on the FE instance
        fwd(1'b1, 1'b0, 8'h81);
        fwd(1'b0, 1'b0, 8'h82);
        fwd(1'b0, 1'b1, 8'h83);
        fwd(1'b1, 1'b1, 8'h84);
`ifdef QUAD2STEER_SAT_EN
        check("sat_count", w_count, 8'hFF);
`else
        check("wrap_count", w_count, 8'h02);
`endif
        // priming with encoder resting at 11 through reset
        do_reset(3);
        wait_cyc(30);
        check("prime_count", count, 8'h80);
        check("prime_dir", dir, 0);
        check("prime_right", right, 0);
        // reset during an active hold
        push(1'b0, 1'b1, 8'h81, 1'b0, 1'b1);
        set_ab(1'b1, 1'b0);
        wait_step(30);
        wait_cyc(1);
        check("prehold_right", right, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_right", right, 0);
        check("midrst_count", count, 8'h80);
        reset_n = 1'b1;
        wait_cyc(30);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
